ctlb_refill: RTL and testbench
==============================

Name: ctlb_refill

Overview:
- Miss handler directly downstream of the code TLB lookup.
- Watches each fetch-side lookup; on a miss it stalls fetch and issues one page-walk request per miss.
- On a good response it writes the translation back through the code TLB write port (data, wen, nat flag), then holds one replay cycle so fetch re-looks-up and hits.
- Walk faults and aborts are reported to the frontend exception logic; a saturating miss counter feeds performance CSRs.

Parameters:
- OUTDATA_WIDTH, `ctlbData_width: width of one translation payload.
- IP_WIDTH, 52: virtual page address width (64-12).
- TIMEOUT_CYCLES, 255: walk-response timeout limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- lookup_en  in  1  code TLB lookup performed this cycle (read_clkEn & ~fStall).
- lookup_addr  in  IP_WIDTH  looked-up virtual page.
- lookup_nat  in  1  lookup was a native-jump lookup.
- lookup_hit  in  1  code TLB hit for this lookup (same cycle).
- flush  in  1  frontend redirect; abandon the current miss.
- refill_stall  out  1  stall to fetch while a refill is active.
- walk_req  out  1  page-walk request valid.
- walk_gnt  in  1  walker accepts the request.
- walk_addr  out  IP_WIDTH  page to walk.
- walk_nat  out  1  nat flag of the request.
- walk_rsp  in  1  walker response valid (one cycle).
- walk_fault  in  1  response is a fault; qualified by walk_rsp.
- walk_data  in  OUTDATA_WIDTH  translation payload.
- ctlb_wdata  out  OUTDATA_WIDTH  code TLB write data.
- ctlb_wen  out  1  code TLB write enable.
- ctlb_wnat  out  1  write targets the nat-valid bit.
- fault_valid  out  1  one-cycle fault report.
- fault_addr  out  IP_WIDTH  faulting page.
- fault_code  out  2  01 = walk fault, 10 = timeout.
- miss_cnt  out  16  saturating miss count.

Behaviour:
- States: IDLE, REQ, WAIT, WRITE, REPLAY, FAULT.
- Reset: state=IDLE. All outputs are 0, including miss_cnt and the captured addr/nat/data registers.
- IDLE:
  - Miss = lookup_en & ~lookup_hit & ~flush.
  - On a miss: capture addr/nat, go to REQ, and increment miss_cnt. miss_cnt saturates at 16'hFFFF and does not wrap.
  - Hits cause no state change.
- refill_stall is asserted combinationally in the miss cycle and registered in every non-IDLE state. It deasserts in the cycle after REPLAY.
- REQ:
  - walk_req=1, with walk_addr/walk_nat driven from the captured registers and held stable until walk_gnt.
  - walk_gnt: go to WAIT (walk_req low the next cycle).
  - flush with no gnt in the same cycle: go to IDLE, no request outstanding.
  - flush and gnt in the same cycle: the grant wins; go to WAIT with drop=1.
- WAIT:
  - flush sets drop=1; the state stays in WAIT, since exactly one response is owed.
  - walk_rsp with drop=1: discard the response, go to IDLE, no write, no fault.
  - walk_rsp & walk_fault: go to FAULT.
  - walk_rsp & ~walk_fault: capture walk_data, go to WRITE.
  - walk_rsp in any state other than WAIT is ignored.
- WRITE: ctlb_wen=1 for exactly one cycle, ctlb_wdata=captured data, ctlb_wnat=captured nat. Next state REPLAY.
  - A flush in this cycle does not cancel the write; the translation remains valid.
- REPLAY: stall held 1 cycle (code TLB write is registered internally); then IDLE.
  - Lookups during REPLAY are not treated as misses.
- FAULT: fault_valid=1 for one cycle with fault_addr=captured addr and fault_code=01 (10 for timeout). Then IDLE; the stall drops the following cycle.
  - A flush in this cycle suppresses fault_valid.
- Total latency with gnt and rsp each arriving one cycle after the previous state: miss -> ctlb_wen in 4 cycles; stall active for 6 cycles.
- Reset mid-refill: immediate return to IDLE, outputs cleared, drop cleared. Any late walk response is ignored.
- At most one outstanding walk at any time.

Optional Feature:
- CTLB_REFILL_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without walk_rsp: go to FAULT with fault_code=10, then IDLE. A later stray rsp is ignored.
  - If drop=1 at timeout: go to IDLE silently.
- CTLB_REFILL_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely and fault_code is never 10.

Test Plan:
- Miss at 0x12345, nat=0, gnt and rsp after 1 cycle each, data=D -> walk_addr=0x12345; ctlb_wen one cycle with wdata=D, wnat=0; stall 6 cycles; miss_cnt=1.
- Nat miss, rsp with walk_fault=1 -> no ctlb_wen; fault_valid one cycle, fault_code=01, fault_addr=captured page.
- flush in REQ before gnt -> IDLE next cycle, walk_req low, no write. flush in WAIT, then rsp 5 cycles later -> rsp discarded, no write, no fault.
- Reset asserted in WAIT, rsp arrives after reset -> all outputs 0, state IDLE, no write.
- Preload miss_cnt to 0xFFFF via repeated misses -> stays 0xFFFF after a further miss.
- With CTLB_REFILL_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp -> fault_valid with code 10 exactly 8 cycles after entering WAIT.

Source files
------------

// File: rtl/ctlb_refill.sv
// ---------------------------------------------------------------------------
// ctlb_refill
//
// Purpose:
//   Miss handler sitting directly behind the code TLB lookup. A fetch-side
//   lookup that misses stalls fetch and issues exactly one page-walk request.
//   A good walk response is written back through the code TLB write port, and
//   one replay cycle follows so that fetch re-looks-up and hits. Walk faults
//   (and, optionally, walk timeouts) are reported to the frontend exception
//   logic. A saturating miss counter feeds the performance CSRs.
//
// Optional feature (compile-time macro):
//   CTLB_REFILL_TIMEOUT_EN - enables an 8-bit walk-response timeout. When it
//   is undefined, WAIT lasts until the response and fault_code is never 10.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   lookup_en/addr/nat/hit    code TLB lookup of this cycle and its hit result
//   flush                     frontend redirect, abandons the current miss
//   refill_stall              fetch stall while a refill is active
//   walk_req/addr/nat, gnt    page-walk request handshake
//   walk_rsp/fault/data       one-cycle walk response
//   ctlb_wdata/wen/wnat       code TLB write port
//   fault_valid/addr/code     one-cycle fault report (01 fault, 10 timeout)
//   miss_cnt                  saturating 16-bit miss count
// ---------------------------------------------------------------------------
`ifndef ctlbData_width
`define ctlbData_width 64
`endif

module ctlb_refill #(
    parameter int OUTDATA_WIDTH  = `ctlbData_width,
    parameter int IP_WIDTH       = 52,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_en,
    input  logic [IP_WIDTH-1:0]      lookup_addr,
    input  logic                     lookup_nat,
    input  logic                     lookup_hit,
    input  logic                     flush,
    output logic                     refill_stall,
    output logic                     walk_req,
    input  logic                     walk_gnt,
    output logic [IP_WIDTH-1:0]      walk_addr,
    output logic                     walk_nat,
    input  logic                     walk_rsp,
    input  logic                     walk_fault,
    input  logic [OUTDATA_WIDTH-1:0] walk_data,
    output logic [OUTDATA_WIDTH-1:0] ctlb_wdata,
    output logic                     ctlb_wen,
    output logic                     ctlb_wnat,
    output logic                     fault_valid,
    output logic [IP_WIDTH-1:0]      fault_addr,
    output logic [1:0]               fault_code,
    output logic [15:0]              miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_REPLAY,
        S_FAULT
    } state_t;

    state_t                   r_state;
    logic [IP_WIDTH-1:0]      r_addr;
    logic                     r_nat;
    logic [OUTDATA_WIDTH-1:0] r_data;
    logic                     r_drop;
    logic                     r_walk_req;
    logic                     r_wen;
    logic                     r_fault;
    logic [1:0]               r_code;
    logic [15:0]              r_miss_cnt;

    logic w_miss;
    logic w_discard;
    logic w_timeout;

    // Only lookups seen while idle can start a refill; a redirect in the
    // same cycle means the lookup is stale and is not counted.
    assign w_miss    = (r_state == S_IDLE) & lookup_en & ~lookup_hit & ~flush;

    // A redirect arriving together with the response also abandons it.
    assign w_discard = r_drop | flush;

`ifdef CTLB_REFILL_TIMEOUT_EN
    logic [7:0] r_tmo;

    // The counter holds the number of WAIT cycles already spent, so the
    // last permitted cycle is TIMEOUT_CYCLES-1.
    assign w_timeout = (r_tmo == 8'(TIMEOUT_CYCLES - 1));
`else
    logic [7:0] w_unused_tmo;

    assign w_unused_tmo = 8'(TIMEOUT_CYCLES);
    assign w_timeout    = 1'b0;
`endif

    // Refill state machine. Strobes (write enable, fault report) default low
    // and are raised only on the transition into their one-cycle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_nat      <= 1'b0;
            r_data     <= '0;
            r_drop     <= 1'b0;
            r_walk_req <= 1'b0;
            r_wen      <= 1'b0;
            r_fault    <= 1'b0;
            r_code     <= 2'b00;
            r_miss_cnt <= 16'h0000;
`ifdef CTLB_REFILL_TIMEOUT_EN
            r_tmo      <= 8'd0;
`endif
        end else begin
            r_wen   <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_addr     <= lookup_addr;
                        r_nat      <= lookup_nat;
                        r_drop     <= 1'b0;
                        r_walk_req <= 1'b1;
                        r_state    <= S_REQ;
                        if (r_miss_cnt != 16'hFFFF) begin
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        end
                    end
                end
                S_REQ: begin
                    // Once granted, a response is owed even if flushed now.
                    if (walk_gnt) begin
                        r_walk_req <= 1'b0;
                        r_drop     <= flush;
                        r_state    <= S_WAIT;
`ifdef CTLB_REFILL_TIMEOUT_EN
                        r_tmo      <= 8'd0;
`endif
                    end else if (flush) begin
                        r_walk_req <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_WAIT: begin
`ifdef CTLB_REFILL_TIMEOUT_EN
                    r_tmo <= r_tmo + 8'd1;
`endif
                    if (walk_rsp) begin
                        if (w_discard) begin
                            r_state <= S_IDLE;
                        end else if (walk_fault) begin
                            r_fault <= 1'b1;
                            r_code  <= 2'b01;
                            r_state <= S_FAULT;
                        end else begin
                            r_data  <= walk_data;
                            r_wen   <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end else if (w_timeout) begin
                        if (w_discard) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_fault <= 1'b1;
                            r_code  <= 2'b10;
                            r_state <= S_FAULT;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_REPLAY;
                end
                S_REPLAY: begin
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_code  <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The miss cycle itself must already stall fetch, before the state
    // register has left IDLE.
    assign refill_stall = w_miss | (r_state != S_IDLE);
    assign walk_req     = r_walk_req;
    assign walk_addr    = r_addr;
    assign walk_nat     = r_nat;
    assign ctlb_wdata   = r_data;
    assign ctlb_wen     = r_wen;
    assign ctlb_wnat    = r_nat;
    assign fault_valid  = r_fault & ~flush;
    assign fault_addr   = r_addr;
    assign fault_code   = r_code;
    assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_ctlb_refill.sv
// ---------------------------------------------------------------------------
// tb_ctlb_refill
//
// Directed bench for ctlb_refill. Each scenario is described by a few
// timeline numbers (grant delay, response delay, flush/reset position); the
// expected outputs for every cycle are computed from those numbers, and one
// compare process checks the DUT against them on each falling edge.
// A few literal checks after the first scenario pin the timeline arithmetic.
// ---------------------------------------------------------------------------
module tb_ctlb_refill;

    localparam int DW = 64;
    localparam int AW = 52;
`ifdef CTLB_REFILL_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    localparam int K_GOOD      = 0;
    localparam int K_FAULT     = 1;
    localparam int K_FLUSHREQ  = 2;
    localparam int K_FLUSHWAIT = 3;
    localparam int K_RESET     = 4;
    localparam int K_TMO       = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_en;
    logic [AW-1:0] lookup_addr;
    logic          lookup_nat;
    logic          lookup_hit;
    logic          flush;
    logic          refill_stall;
    logic          walk_req;
    logic          walk_gnt;
    logic [AW-1:0] walk_addr;
    logic          walk_nat;
    logic          walk_rsp;
    logic          walk_fault;
    logic [DW-1:0] walk_data;
    logic [DW-1:0] ctlb_wdata;
    logic          ctlb_wen;
    logic          ctlb_wnat;
    logic          fault_valid;
    logic [AW-1:0] fault_addr;
    logic [1:0]    fault_code;
    logic [15:0]   miss_cnt;

    ctlb_refill #(
        .OUTDATA_WIDTH (DW),
        .IP_WIDTH      (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lookup_en   (lookup_en),
        .lookup_addr (lookup_addr),
        .lookup_nat  (lookup_nat),
        .lookup_hit  (lookup_hit),
        .flush       (flush),
        .refill_stall(refill_stall),
        .walk_req    (walk_req),
        .walk_gnt    (walk_gnt),
        .walk_addr   (walk_addr),
        .walk_nat    (walk_nat),
        .walk_rsp    (walk_rsp),
        .walk_fault  (walk_fault),
        .walk_data   (walk_data),
        .ctlb_wdata  (ctlb_wdata),
        .ctlb_wen    (ctlb_wen),
        .ctlb_wnat   (ctlb_wnat),
        .fault_valid (fault_valid),
        .fault_addr  (fault_addr),
        .fault_code  (fault_code),
        .miss_cnt    (miss_cnt)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Expected values for the current cycle, written by the driver.
    bit            expOn = 1'b0;
    bit            eStall, eReq, eWen, eFault, eAllZero;
    logic [AW-1:0] eAddr;
    bit            eNat;
    logic [DW-1:0] eData;
    logic [1:0]    eCode;
    logic [15:0]   eCnt;
    logic [15:0]   modelCnt = 16'h0000;

    // Bookkeeping used by the literal checks that pin the timeline model.
    int            scCycle;
    int            stallCount;
    int            wenCycle;
    logic [AW-1:0] seenWalkAddr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Single compare process: checks every output on each falling edge while
    // a scenario is running, with the payload fields checked only while their
    // strobe is expected.
    always @(negedge clk) begin
        if (expOn) begin
            checkOutput("refill_stall", 64'(refill_stall), 64'(eStall));
            checkOutput("walk_req", 64'(walk_req), 64'(eReq));
            checkOutput("ctlb_wen", 64'(ctlb_wen), 64'(eWen));
            checkOutput("fault_valid", 64'(fault_valid), 64'(eFault));
            checkOutput("miss_cnt", 64'(miss_cnt), 64'(eCnt));
            if (eReq) begin
                checkOutput("walk_addr", 64'(walk_addr), 64'(eAddr));
                checkOutput("walk_nat", 64'(walk_nat), 64'(eNat));
            end
            if (eWen) begin
                checkOutput("ctlb_wdata", 64'(ctlb_wdata), 64'(eData));
                checkOutput("ctlb_wnat", 64'(ctlb_wnat), 64'(eNat));
            end
            if (eFault) begin
                checkOutput("fault_addr", 64'(fault_addr), 64'(eAddr));
                checkOutput("fault_code", 64'(fault_code), 64'(eCode));
            end
            if (eAllZero) begin
                checkOutput("rst_walk_addr", 64'(walk_addr), 64'd0);
                checkOutput("rst_wdata", 64'(ctlb_wdata), 64'd0);
                checkOutput("rst_fault_code", 64'(fault_code), 64'd0);
            end
            if (refill_stall) stallCount++;
            if (ctlb_wen) wenCycle = scCycle;
            if (walk_req) seenWalkAddr = walk_addr;
        end
    end

    // Runs one miss scenario. The miss is at cycle 0; the grant comes g REQ
    // cycles later (cycle 1+g), WAIT starts at 2+g and the response arrives
    // r WAIT cycles after that. p positions the flush/reset for those kinds.
    task automatic applyStimulus(input int kind, input logic [AW-1:0] addr, input bit nat,
                                 input logic [DW-1:0] data, input int g, input int r,
                                 input int p, input bit extraFlush);
        int            wStart, w, eEnd, len, reqEnd;
        logic [15:0]   cntBefore;
        wStart = 2 + g;
        w      = wStart + r;
        reqEnd = 1 + g;
        case (kind)
            K_GOOD:      eEnd = w + 2;
            K_FAULT:     eEnd = w + 1;
            K_FLUSHREQ:  begin eEnd = 1 + p; reqEnd = 1 + p; end
            K_FLUSHWAIT: eEnd = w;
            K_RESET:     eEnd = wStart + p;
            default:     eEnd = wStart + TMO;
        endcase
        len          = eEnd + 4;
        cntBefore    = modelCnt;
        stallCount   = 0;
        wenCycle     = -1;
        seenWalkAddr = '0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            scCycle     = c;
            rst         = 1'b0;
            lookup_addr = {$urandom, $urandom} & {AW{1'b1}};
            lookup_nat  = 1'($urandom);
            walk_data   = {$urandom, $urandom};
            flush       = 1'b0;
            walk_gnt    = 1'b0;
            walk_rsp    = 1'b0;
            walk_fault  = 1'b0;
            if (c == 0) begin
                lookup_en = 1'b1; lookup_hit = 1'b0;
                lookup_addr = addr; lookup_nat = nat;
            end else if (c <= eEnd) begin
                lookup_en = 1'b1; lookup_hit = 1'b0;
            end else begin
                lookup_en = 1'b1; lookup_hit = 1'b1;
            end
            if (kind != K_FLUSHREQ && c == 1 + g) walk_gnt = 1'b1;
            if ((kind == K_GOOD || kind == K_FAULT || kind == K_FLUSHWAIT) && c == w) begin
                walk_rsp   = 1'b1;
                walk_fault = (kind == K_FAULT);
                walk_data  = data;
            end
            if ((kind == K_GOOD && c == w + 2) || c == eEnd + 1 || (kind == K_RESET && c == eEnd + 2)) begin
                walk_rsp   = 1'b1;
                walk_fault = 1'b1;
            end
            if (c == eEnd + 2) begin
                lookup_hit = 1'b0; flush = 1'b1;
            end
            if (kind == K_FLUSHREQ && c == 1 + p) flush = 1'b1;
            if (kind == K_FLUSHWAIT && c == wStart + p) flush = 1'b1;
            if (extraFlush && (kind == K_GOOD || kind == K_FAULT) && c == w + 1) flush = 1'b1;
            if (kind == K_RESET && c == eEnd) rst = 1'b1;

            eStall   = (c <= eEnd);
            eReq     = (c >= 1 && c <= reqEnd);
            eWen     = (kind == K_GOOD && c == w + 1);
            eFault   = ((kind == K_FAULT && c == w + 1 && !extraFlush) || (kind == K_TMO && c == eEnd));
            eCode    = (kind == K_TMO) ? 2'b10 : 2'b01;
            eAddr    = addr;
            eNat     = nat;
            eData    = data;
            eAllZero = (kind == K_RESET && c > eEnd);
            if (c == 0) eCnt = cntBefore;
            else if (kind == K_RESET && c > eEnd) eCnt = 16'h0000;
            else eCnt = satInc(cntBefore);
            expOn = 1'b1;
        end
        @(negedge clk);
        #1;
        expOn    = 1'b0;
        modelCnt = (kind == K_RESET) ? 16'h0000 : satInc(cntBefore);
    endtask

    // Main sequence: reset checks, then the directed scenario list.
    initial begin
        rst = 1'b1; lookup_en = 1'b0; lookup_addr = '0; lookup_nat = 1'b0;
        lookup_hit = 1'b0; flush = 1'b0; walk_gnt = 1'b0; walk_rsp = 1'b0;
        walk_fault = 1'b0; walk_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", 64'(refill_stall), 64'd0);
        checkOutput("reset_walk_req", 64'(walk_req), 64'd0);
        checkOutput("reset_wen", 64'(ctlb_wen), 64'd0);
        checkOutput("reset_fault_valid", 64'(fault_valid), 64'd0);
        checkOutput("reset_miss_cnt", 64'(miss_cnt), 64'd0);
        checkOutput("reset_walk_addr", 64'(walk_addr), 64'd0);

        applyStimulus(K_GOOD, 52'h12345, 1'b0, 64'hDEAD_BEEF_0123_4567, 0, 1, 0, 1'b0);
        checkOutput("lit_stall_cycles", 64'(stallCount), 64'd6);
        checkOutput("lit_wen_cycle", 64'(wenCycle), 64'd4);
        checkOutput("lit_walk_addr", 64'(seenWalkAddr), 64'h12345);
        checkOutput("lit_miss_cnt", 64'(miss_cnt), 64'd1);

        applyStimulus(K_FAULT, 52'hABCDE, 1'b1, 64'h0, 1, 2, 0, 1'b0);
        applyStimulus(K_FLUSHREQ, 52'h00777, 1'b0, 64'h0, 99, 0, 1, 1'b0);
        applyStimulus(K_FLUSHWAIT, 52'h55555, 1'b1, 64'h1111, 0, 5, 0, 1'b0);
        applyStimulus(K_FLUSHWAIT, 52'h66666, 1'b0, 64'h2222, 2, 3, -1, 1'b0);
        applyStimulus(K_GOOD, 52'hF_FFFF_FFFF_FFFF, 1'b1, 64'hCAFE_F00D_0000_0001, 2, 0, 0, 1'b1);
        applyStimulus(K_FAULT, 52'h13579, 1'b0, 64'h0, 0, 0, 0, 1'b1);
        applyStimulus(K_RESET, 52'h24680, 1'b1, 64'h0, 0, 0, 1, 1'b0);
        checkOutput("lit_cnt_after_reset", 64'(miss_cnt), 64'd0);

        // Bring the counter next to saturation instead of 65534 real misses.
        @(posedge clk);
        #1;
        force dut.r_miss_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_miss_cnt;
        modelCnt = 16'hFFFE;
        applyStimulus(K_GOOD, 52'h00042, 1'b0, 64'h4242, 0, 1, 0, 1'b0);
        checkOutput("lit_cnt_sat", 64'(miss_cnt), 64'hFFFF);
        applyStimulus(K_FLUSHREQ, 52'h00043, 1'b1, 64'h0, 99, 0, 0, 1'b0);
        checkOutput("lit_cnt_stays_sat", 64'(miss_cnt), 64'hFFFF);

`ifdef CTLB_REFILL_TIMEOUT_EN
        applyStimulus(K_TMO, 52'h99999, 1'b1, 64'h0, 0, 0, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the bench always ends even if a scenario stalls.
    initial begin
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
